dram_byte_bridge: RTL and testbench

Bridges the CPU data-memory port (32-bit loads/stores of byte, half, or word size) to the byte-wide DRAM on the motherboard bus. Each request is serialised into 1, 2 or 4 little-endian byte accesses. Store bytes are driven so the DRAM captures them on its negative-edge write. Load bytes are sampled from the DRAM's combinational read data on the positive edge. Finished loads are returned zero- or sign-extended with a single-cycle response pulse.

---
 rtl/dram_byte_bridge_pkg.sv | 34 +++
 rtl/dram_byte_bridge_load_extend.sv | 23 ++
 rtl/dram_byte_bridge.sv | 152 +++++++++++++++
 tb/tb_dram_byte_bridge.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_byte_bridge_pkg.sv
// Shared encodings for the CPU load/store path and the byte-wide DRAM bridge.
// Also holds small decode helpers used by more than one file.
package dram_byte_bridge_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Index of the final byte beat for a request size.
  function automatic logic [1:0] last_cnt(input logic [1:0] size);
    case (size)
      SIZE_HALF: last_cnt = 2'd1;
      SIZE_WORD: last_cnt = 2'd3;
      default:   last_cnt = 2'd0;
    endcase
  endfunction

  // Illegal size, or an address not aligned to its access size.
  function automatic logic req_bad(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: req_bad = 1'b0;
      SIZE_HALF: req_bad = addr_lo[0];
      SIZE_WORD: req_bad = (addr_lo != 2'b00);
      default:   req_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dram_byte_bridge_load_extend.sv
// Zero/sign extension of an assembled little-endian load value.
// Purely combinational so the cache path can reuse it as-is.
module load_extend
  import dram_byte_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [1:0]            size,
  input  logic                  sign_en,
  output logic [DATA_WIDTH-1:0] data_out
);

  always_comb begin
    data_out = data_in;
    case (size)
      SIZE_BYTE: data_out = {{(DATA_WIDTH-8){sign_en & data_in[7]}}, data_in[7:0]};
      SIZE_HALF: data_out = {{(DATA_WIDTH-16){sign_en & data_in[15]}}, data_in[15:0]};
      default:   data_out = data_in;
    endcase
  end

endmodule

// File: rtl/dram_byte_bridge.sv
// Serialises 32-bit CPU loads/stores into little-endian byte accesses on the
// byte-wide DRAM bus, then returns one extended response pulse.
module dram_byte_bridge
  import dram_byte_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_we,
  input  logic [7:0]            mem_rdata
);

  localparam int NLANES = DATA_WIDTH / 8;

  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  write_q, write_d;
  logic                  signed_q, signed_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [7:0]            lane_q [NLANES];
  logic [7:0]            lane_d [NLANES];
  logic [DATA_WIDTH-1:0] assembled;
  logic [DATA_WIDTH-1:0] extended;
  logic                  accept;
  logic                  capture;

  // Ready is masked by rst so the CPU never sees a transfer during reset.
  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign capture   = (state_q == ST_XFER) && !write_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    size_d   = size_q;
    write_d  = write_q;
    signed_d = signed_q;
    err_d    = err_q;
    wdata_d  = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d   = req_addr;
          size_d   = req_size;
          write_d  = req_write;
          signed_d = req_signed;
          wdata_d  = req_wdata;
          cnt_d    = 2'd0;
          err_d    = req_bad(req_size, req_addr[1:0]);
          state_d  = req_bad(req_size, req_addr[1:0]) ? ST_RESP : ST_XFER;
        end
      end
      ST_XFER: begin
        if (cnt_q == last_cnt(size_q)) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture register: each lane loads mem_rdata on its own beat and is
  // cleared at acceptance so stale bytes never leak into a shorter load.
  for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
    localparam logic [1:0] LANE_IDX = 2'(gi);
    always_comb begin
      lane_d[gi] = lane_q[gi];
      if (accept) begin
        lane_d[gi] = 8'h00;
      end else if (capture && (cnt_q == LANE_IDX)) begin
        lane_d[gi] = mem_rdata;
      end
    end
    assign assembled[8*gi +: 8] = lane_q[gi];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 2'd0;
      addr_q   <= '0;
      size_q   <= 2'd0;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      for (int i = 0; i < NLANES; i++) lane_q[i] <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      write_q  <= write_d;
      signed_q <= signed_d;
      err_q    <= err_d;
      wdata_q  <= wdata_d;
      for (int i = 0; i < NLANES; i++) lane_q[i] <= lane_d[i];
    end
  end

  load_extend #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_extend (
    .data_in (assembled),
    .size    (size_q),
    .sign_en (signed_q),
    .data_out(extended)
  );

  // Bus outputs come only from registered state, so they hold steady across
  // the negedge at which the DRAM commits a write.
  always_comb begin
    mem_addr   = '0;
    mem_wdata  = 8'h00;
    mem_we     = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    if (state_q == ST_XFER) begin
      mem_addr  = {addr_q[ADDR_WIDTH-1:2], addr_q[1:0] + cnt_q};
      mem_wdata = wdata_q[{cnt_q, 3'b000} +: 8];
      mem_we    = write_q;
    end
    if (state_q == ST_RESP) begin
      resp_valid = 1'b1;
      resp_err   = err_q;
      if (!err_q && !write_q) resp_rdata = extended;
    end
  end

endmodule

// File: tb/tb_dram_byte_bridge.sv
// Self-checking bench for dram_byte_bridge with a negedge-write DRAM model
// and a scoreboard of expected responses.
module tb_dram_byte_bridge;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  logic [7:0] dram [0:65535];

  dram_byte_bridge #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_size  (req_size),
    .req_signed(req_signed),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) dram[mem_addr[15:0]] = mem_wdata;
  end
  assign mem_rdata = dram[mem_addr[15:0]];

  // One request through the DUT, checking bus beats, latency and response.
  task automatic do_req(input string name, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] ad, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_er, input int exp_lat);
    exp_t e;
    int c;
    int nb;
    logic [31:0] ea;
    @(negedge clk);
    chk_cnt++;
    if (req_ready !== 1'b1) $display("FAIL %s ready_before_accept got %b want 1", name, req_ready);
    else pass_cnt++;
    req_write = wr; req_size = sz; req_signed = sg; req_addr = ad; req_wdata = wd;
    req_valid = 1'b1;
    e.rdata = exp_rd; e.err = exp_er; e.lat = exp_lat;
    sb.push_back(e);
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    @(posedge clk); #1;
    req_valid = 1'b0;
    c = 1;
    while (resp_valid !== 1'b1 && c < 16) begin
      if (exp_er) begin
        chk_cnt++;
        if (mem_we !== 1'b0) $display("FAIL %s err_no_we cycle %0d got %b want 0", name, c, mem_we);
        else pass_cnt++;
      end else if (c <= nb) begin
        ea = ad + 32'(c - 1);
        chk_cnt++;
        if (mem_addr !== ea) $display("FAIL %s mem_addr cycle %0d got %h want %h", name, c, mem_addr, ea);
        else pass_cnt++;
        chk_cnt++;
        if (mem_we !== wr) $display("FAIL %s mem_we cycle %0d got %b want %b", name, c, mem_we, wr);
        else pass_cnt++;
        if (wr) begin
          chk_cnt++;
          if (mem_wdata !== wd[8*(c-1) +: 8])
            $display("FAIL %s mem_wdata cycle %0d got %h want %h", name, c, mem_wdata, wd[8*(c-1) +: 8]);
          else pass_cnt++;
        end
      end
      @(posedge clk); #1;
      c++;
    end
    e = sb.pop_front();
    chk_cnt++;
    if (resp_valid !== 1'b1) $display("FAIL %s resp_timeout got %b want 1", name, resp_valid);
    else pass_cnt++;
    chk_cnt++;
    if (c != e.lat) $display("FAIL %s latency got %0d want %0d", name, c, e.lat);
    else pass_cnt++;
    chk_cnt++;
    if (resp_rdata !== e.rdata) $display("FAIL %s rdata got %h want %h", name, resp_rdata, e.rdata);
    else pass_cnt++;
    chk_cnt++;
    if (resp_err !== e.err) $display("FAIL %s err got %b want %b", name, resp_err, e.err);
    else pass_cnt++;
    chk_cnt++;
    if (mem_we !== 1'b0) $display("FAIL %s resp_we got %b want 0", name, mem_we);
    else pass_cnt++;
    $display("txn %s wr=%0d size=%0d signed=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             name, wr, sz, sg, ad, wd, resp_rdata, resp_err, c);
    @(posedge clk); #1;
    chk_cnt++;
    if (resp_valid !== 1'b0) $display("FAIL %s resp_one_cycle got %b want 0", name, resp_valid);
    else pass_cnt++;
    chk_cnt++;
    if (req_ready !== 1'b1) $display("FAIL %s ready_after_resp got %b want 1", name, req_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if (req_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", req_ready);
    else pass_cnt++;
    chk_cnt++;
    if ({resp_valid, resp_err, resp_rdata} !== 34'd0)
      $display("FAIL reset_resp got %b/%b/%h want 0/0/0", resp_valid, resp_err, resp_rdata);
    else pass_cnt++;
    chk_cnt++;
    if ({mem_we, mem_wdata, mem_addr} !== 41'd0)
      $display("FAIL reset_mem got %b/%h/%h want 0/0/0", mem_we, mem_wdata, mem_addr);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_cnt++;
    if (req_ready !== 1'b1) $display("FAIL reset_release_ready got %b want 1", req_ready);
    else pass_cnt++;
    $display("txn reset released");
  endtask

  task automatic test_word_store();
    logic [31:0] rb;
    do_req("word_store", 1'b1, 2'b10, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 1'b0, 5);
    rb = {dram[16'h1003], dram[16'h1002], dram[16'h1001], dram[16'h1000]};
    chk_cnt++;
    if (rb !== 32'hDEAD_BEEF) $display("FAIL dram_readback got %h want DEADBEEF", rb);
    else pass_cnt++;
  endtask

  task automatic test_byte_load();
    do_req("byte_load_s", 1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0, 32'hFFFF_FFDE, 1'b0, 2);
    do_req("byte_load_u", 1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 32'h0000_00DE, 1'b0, 2);
  endtask

  task automatic test_half_load();
    do_req("half_load_s", 1'b0, 2'b01, 1'b1, 32'h0000_1002, 32'h0, 32'hFFFF_DEAD, 1'b0, 3);
    do_req("half_load_u", 1'b0, 2'b01, 1'b0, 32'h0000_1000, 32'h0, 32'h0000_BEEF, 1'b0, 3);
    do_req("word_load",   1'b0, 2'b10, 1'b1, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 1'b0, 5);
  endtask

  task automatic test_errors();
    do_req("half_misalign", 1'b0, 2'b01, 1'b1, 32'h0000_1001, 32'h0, 32'h0, 1'b1, 1);
    do_req("illegal_size",  1'b1, 2'b11, 1'b0, 32'h0000_2000, 32'h1234_5678, 32'h0, 1'b1, 1);
    do_req("word_misalign", 1'b1, 2'b10, 1'b0, 32'h0000_1002, 32'h1111_1111, 32'h0, 1'b1, 1);
    chk_cnt++;
    if (dram[16'h1002] !== 8'hAD) $display("FAIL err_no_write got %h want AD", dram[16'h1002]);
    else pass_cnt++;
  endtask

  task automatic test_read_after_write();
    do_req("byte_store", 1'b1, 2'b00, 1'b0, 32'h0000_1001, 32'h0000_007F, 32'h0, 1'b0, 2);
    do_req("raw_half",   1'b0, 2'b01, 1'b1, 32'h0000_1000, 32'h0, 32'h0000_7FEF, 1'b0, 3);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    @(negedge clk);
    req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h0000_1003;
    req_valid = 1'b1;
    e.rdata = 32'h0000_00DE; e.err = 1'b0; e.lat = 2; sb.push_back(e);
    @(posedge clk); #1;
    chk_cnt++;
    if (req_ready !== 1'b0) $display("FAIL b2b_ready_xfer got %b want 0", req_ready);
    else pass_cnt++;
    req_addr = 32'h0000_1000;
    e.rdata = 32'h0000_00EF; e.err = 1'b0; e.lat = 2; sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk_cnt++;
    if (resp_valid !== 1'b1 || resp_rdata !== e.rdata)
      $display("FAIL b2b_first got %b/%h want 1/%h", resp_valid, resp_rdata, e.rdata);
    else pass_cnt++;
    chk_cnt++;
    if (req_ready !== 1'b0) $display("FAIL b2b_ready_resp got %b want 0", req_ready);
    else pass_cnt++;
    $display("txn b2b_first addr=00001003 rdata=%h", resp_rdata);
    @(posedge clk); #1;
    chk_cnt++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0)
      $display("FAIL b2b_idle got ready=%b valid=%b want 1/0", req_ready, resp_valid);
    else pass_cnt++;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk_cnt++;
    if (mem_addr !== 32'h0000_1000 || req_ready !== 1'b0)
      $display("FAIL b2b_second_xfer got addr=%h ready=%b want 00001000/0", mem_addr, req_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    e = sb.pop_front();
    chk_cnt++;
    if (resp_valid !== 1'b1 || resp_rdata !== e.rdata)
      $display("FAIL b2b_second got %b/%h want 1/%h", resp_valid, resp_rdata, e.rdata);
    else pass_cnt++;
    $display("txn b2b_second addr=00001000 rdata=%h", resp_rdata);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op();
    bit saw_resp;
    do_req("preload_3000", 1'b1, 2'b10, 1'b0, 32'h0000_3000, 32'h4433_2211, 32'h0, 1'b0, 5);
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h0000_3000; req_wdata = 32'hA5A5_A5A5; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk_cnt++;
    if (mem_we !== 1'b1) $display("FAIL abort_pre_we got %b want 1", mem_we);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if (mem_we !== 1'b0) $display("FAIL abort_we_drop got %b want 0", mem_we);
    else pass_cnt++;
    chk_cnt++;
    if (req_ready !== 1'b0) $display("FAIL abort_ready got %b want 0", req_ready);
    else pass_cnt++;
    saw_resp = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (resp_valid === 1'b1) saw_resp = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_cnt++;
    if (req_ready !== 1'b1) $display("FAIL abort_release_ready got %b want 1", req_ready);
    else pass_cnt++;
    repeat (3) begin
      @(posedge clk); #1;
      if (resp_valid === 1'b1) saw_resp = 1'b1;
    end
    chk_cnt++;
    if (saw_resp) $display("FAIL abort_no_resp got 1 want 0");
    else pass_cnt++;
    $display("txn aborted word store at 00003000");
    do_req("load_after_abort", 1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0, 32'h4433_22A5, 1'b0, 5);
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_byte_load();
    test_half_load();
    test_errors();
    test_read_after_write();
    test_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
